// File: rtl/expmul_pkg.sv
// Shared types and helpers for the expmul_pipe exp-multiply unit.
// The optional EXPMUL_ROUND_EN macro only affects expmul_shift_lane.
package expmul_pkg;

  localparam int SCORE_WIDTH_DEF = 8;
  localparam int SCORE_FRAC_DEF  = 3;
  localparam int V_WIDTH_DEF     = 18;
  localparam int SHIFT_W         = $clog2(V_WIDTH_DEF);

  // Q-format containers for the default configuration.
  typedef logic signed [SCORE_WIDTH_DEF-1:0] score_t;
  typedef logic signed [V_WIDTH_DEF-1:0]     lane_t;

  // Approximates y*log2(e) as y + y/2 - y/16, then rounds half-up to an integer shift.
  // The 32-bit working width leaves ample headroom for any practical score width.
  function automatic logic [31:0] log2e_shift(input logic [31:0] y, input int frac);
    logic [31:0] l_wide;
    l_wide = y + (y >> 1) - (y >> 4);
    return (l_wide + (32'd1 << (frac - 1))) >> frac;
  endfunction

endpackage

// File: rtl/expmul_shift_lane.sv
// One value lane: arithmetic right shift by l, forced to zero when the shift overflows.
// With EXPMUL_ROUND_EN defined the shift rounds half-up and saturates.
module expmul_shift_lane
  import expmul_pkg::*;
#(
  parameter int V_WIDTH  = V_WIDTH_DEF,
  parameter int SHIFT_W_P = SHIFT_W
) (
  input  logic signed [V_WIDTH-1:0]   v,
  input  logic        [SHIFT_W_P-1:0] l,
  input  logic                        zero,
  output logic signed [V_WIDTH-1:0]   res
);

  localparam int EW = V_WIDTH + 1;

  logic signed [EW-1:0] pre_s;
  logic signed [EW-1:0] stage_s [SHIFT_W_P+1];

`ifdef EXPMUL_ROUND_EN
  logic [EW-1:0] bias_s;

  // Half-LSB bias at the position that the shift will discard.
  always_comb begin
    if (l == {SHIFT_W_P{1'b0}}) begin
      bias_s = '0;
    end else begin
      bias_s = {{(EW-1){1'b0}}, 1'b1} << (l - 1'b1);
    end
  end

  assign pre_s = $signed({v[V_WIDTH-1], v}) + $signed(bias_s);
`else
  assign pre_s = $signed({v[V_WIDTH-1], v});
`endif

  assign stage_s[0] = pre_s;

  for (genvar k = 0; k < SHIFT_W_P; k++) begin : g_bs
    assign stage_s[k+1] = l[k] ? (stage_s[k] >>> (2**k)) : stage_s[k];
  end

  // Zero forcing wins; otherwise clip the extended result back to the lane range.
  always_comb begin
    if (zero) begin
      res = '0;
    end else if (stage_s[SHIFT_W_P][EW-1] != stage_s[SHIFT_W_P][EW-2]) begin
      res = stage_s[SHIFT_W_P][EW-1] ? {1'b1, {(V_WIDTH-1){1'b0}}}
                                     : {1'b0, {(V_WIDTH-1){1'b1}}};
    end else begin
      res = stage_s[SHIFT_W_P][V_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/expmul_pipe.sv
// Three-stage ready/valid pipeline computing v_out[i] ~= exp(a-b) * v_in[i] per lane.
// Define EXPMUL_ROUND_EN for round-half-up shifting instead of truncation.
module expmul_pipe
  import expmul_pkg::*;
#(
  parameter int VEC_LEN     = 64,
  parameter int V_WIDTH     = 18,
  parameter int SCORE_WIDTH = 8,
  parameter int SCORE_FRAC  = 3,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vld_in,
  output logic                         rdy_out,
  input  logic [SCORE_WIDTH-1:0]       a_in,
  input  logic [SCORE_WIDTH-1:0]       b_in,
  input  logic [VEC_LEN*V_WIDTH-1:0]   v_in,
  input  logic [TAG_WIDTH-1:0]         tag_in,
  output logic                         vld_out,
  input  logic                         rdy_in,
  output logic [VEC_LEN*V_WIDTH-1:0]   v_out,
  output logic [TAG_WIDTH-1:0]         tag_out,
  output logic                         clamp_out,
  output logic                         zero_out
);

  localparam int LW = $clog2(V_WIDTH);
  localparam int VW = VEC_LEN * V_WIDTH;
  localparam int DW = SCORE_WIDTH + 1;

  logic                          s1_vld_r;
  logic signed [SCORE_WIDTH-1:0] s1_a_r;
  logic signed [SCORE_WIDTH-1:0] s1_b_r;
  logic [VW-1:0]                 s1_v_r;
  logic [TAG_WIDTH-1:0]          s1_tag_r;

  logic                          s2_vld_r;
  logic [LW-1:0]                 s2_l_r;
  logic                          s2_zero_r;
  logic                          s2_clamp_r;
  logic [VW-1:0]                 s2_v_r;
  logic [TAG_WIDTH-1:0]          s2_tag_r;

  logic                          rdy1_s;
  logic                          rdy2_s;
  logic                          rdy3_s;

  logic signed [DW-1:0]          d_s;
  logic [DW-1:0]                 y_s;
  logic                          clamp_s;
  logic                          zero_s;
  logic [31:0]                   l_full_s;
  logic [LW-1:0]                 l_sat_s;
  logic [VW-1:0]                 res_s;

  // A stage can take new data when empty or when its contents move on this edge.
  assign rdy3_s  = !vld_out  || rdy_in;
  assign rdy2_s  = !s2_vld_r || rdy3_s;
  assign rdy1_s  = !s1_vld_r || rdy2_s;
  assign rdy_out = rdy1_s;

  // Stage 1 capture of the accepted transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_r <= 1'b0;
      s1_a_r   <= '0;
      s1_b_r   <= '0;
      s1_v_r   <= '0;
      s1_tag_r <= '0;
    end else if (rdy1_s) begin
      s1_vld_r <= vld_in;
      if (vld_in) begin
        s1_a_r   <= a_in;
        s1_b_r   <= b_in;
        s1_v_r   <= v_in;
        s1_tag_r <= tag_in;
      end
    end
  end

  // Shift amount from the score difference; positive differences clamp to a zero shift.
  always_comb begin
    d_s     = DW'(s1_a_r) - DW'(s1_b_r);
    clamp_s = !d_s[DW-1] && (d_s != '0);
    if (clamp_s) begin
      y_s = '0;
    end else begin
      y_s = -d_s;
    end
    l_full_s = log2e_shift(32'(y_s), SCORE_FRAC);
    zero_s   = (l_full_s >= 32'(V_WIDTH));
    if (zero_s) begin
      l_sat_s = LW'(V_WIDTH - 1);
    end else begin
      l_sat_s = l_full_s[LW-1:0];
    end
  end

  // Stage 2 register of shift control plus pass-through data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_r   <= 1'b0;
      s2_l_r     <= '0;
      s2_zero_r  <= 1'b0;
      s2_clamp_r <= 1'b0;
      s2_v_r     <= '0;
      s2_tag_r   <= '0;
    end else if (rdy2_s) begin
      s2_vld_r <= s1_vld_r;
      if (s1_vld_r) begin
        s2_l_r     <= l_sat_s;
        s2_zero_r  <= zero_s;
        s2_clamp_r <= clamp_s;
        s2_v_r     <= s1_v_r;
        s2_tag_r   <= s1_tag_r;
      end
    end
  end

  for (genvar i = 0; i < VEC_LEN; i++) begin : g_lane
    expmul_shift_lane #(
      .V_WIDTH  (V_WIDTH),
      .SHIFT_W_P(LW)
    ) u_lane (
      .v   (s2_v_r[i*V_WIDTH +: V_WIDTH]),
      .l   (s2_l_r),
      .zero(s2_zero_r),
      .res (res_s[i*V_WIDTH +: V_WIDTH])
    );
  end

  // Stage 3 output register; holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_out   <= 1'b0;
      v_out     <= '0;
      tag_out   <= '0;
      clamp_out <= 1'b0;
      zero_out  <= 1'b0;
    end else if (rdy3_s) begin
      vld_out <= s2_vld_r;
      if (s2_vld_r) begin
        v_out     <= res_s;
        tag_out   <= s2_tag_r;
        clamp_out <= s2_clamp_r;
        zero_out  <= s2_zero_r;
      end
    end
  end

endmodule

// File: tb/tb_expmul_pipe.sv
// Self-checking bench for expmul_pipe: directed table, random handshake traffic, mid-stream reset.
// Expected lane values come from a real-arithmetic model of 2^-l scaling.
module tb_expmul_pipe;
  import expmul_pkg::*;

  localparam int VEC_LEN     = 64;
  localparam int V_WIDTH     = 18;
  localparam int SCORE_WIDTH = 8;
  localparam int SCORE_FRAC  = 3;
  localparam int TAG_WIDTH   = 4;
  localparam int VW          = VEC_LEN * V_WIDTH;
  localparam int N_RAND      = 20;

  typedef struct {
    int a; int b; int v0; int v1; int tag;
    int e0; int e1; int eclamp; int ezero;
  } vec_t;

  typedef struct {
    logic [VW-1:0]        v;
    logic [TAG_WIDTH-1:0] tag;
    logic                 clamp;
    logic                 zero;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   vld_in;
  logic                   rdy_out;
  logic [SCORE_WIDTH-1:0] a_in;
  logic [SCORE_WIDTH-1:0] b_in;
  logic [VW-1:0]          v_in;
  logic [TAG_WIDTH-1:0]   tag_in;
  logic                   vld_out;
  logic                   rdy_in;
  logic [VW-1:0]          v_out;
  logic [TAG_WIDTH-1:0]   tag_out;
  logic                   clamp_out;
  logic                   zero_out;

  int   n_pass  = 0;
  int   n_total = 0;
  vec_t tbl [7];
  exp_t q [$];

  expmul_pipe #(
    .VEC_LEN(VEC_LEN), .V_WIDTH(V_WIDTH), .SCORE_WIDTH(SCORE_WIDTH),
    .SCORE_FRAC(SCORE_FRAC), .TAG_WIDTH(TAG_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out),
    .a_in(a_in), .b_in(b_in), .v_in(v_in), .tag_in(tag_in),
    .vld_out(vld_out), .rdy_in(rdy_in), .v_out(v_out), .tag_out(tag_out),
    .clamp_out(clamp_out), .zero_out(zero_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    int bad;
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      bad = -1;
      for (int i = VEC_LEN - 1; i >= 0; i--)
        if (act[i*V_WIDTH +: V_WIDTH] !== exp[i*V_WIDTH +: V_WIDTH]) bad = i;
      $display("FAIL %s: lane %0d got %0d, expected %0d", name, bad,
               $signed(act[bad*V_WIDTH +: V_WIDTH]), $signed(exp[bad*V_WIDTH +: V_WIDTH]));
    end
  endtask

  // Integer shift from the score rule: l = round(y + y/2 - y/16) in units of 2^-SCORE_FRAC.
  function automatic int model_l(int a, int b);
    int y, big_l;
    y     = (a > b) ? 0 : b - a;
    big_l = y + y / 2 - y / 16;
    return (big_l + 2 ** (SCORE_FRAC - 1)) / (2 ** SCORE_FRAC);
  endfunction

  function automatic int model_lane(int v, int l);
    real q_r;
    if (l >= V_WIDTH) return 0;
`ifdef EXPMUL_ROUND_EN
    if (l == 0) return v;
    q_r = $floor((real'(v) + 2.0 ** (l - 1)) / (2.0 ** l));
    if (q_r > real'(2 ** (V_WIDTH - 1) - 1)) q_r = real'(2 ** (V_WIDTH - 1) - 1);
    if (q_r < -real'(2 ** (V_WIDTH - 1))) q_r = -real'(2 ** (V_WIDTH - 1));
`else
    q_r = $floor(real'(v) / (2.0 ** l));
`endif
    return int'(q_r);
  endfunction

  function automatic exp_t model(int a, int b, logic [VW-1:0] v, logic [TAG_WIDTH-1:0] tag);
    exp_t e;
    int   l;
    l       = model_l(a, b);
    e.tag   = tag;
    e.clamp = (a > b);
    e.zero  = (l >= V_WIDTH);
    for (int i = 0; i < VEC_LEN; i++)
      e.v[i*V_WIDTH +: V_WIDTH] = V_WIDTH'(model_lane(int'($signed(v[i*V_WIDTH +: V_WIDTH])), l));
    return e;
  endfunction

  // Single transaction through an idle pipe, checking the three-edge latency.
  task automatic run_vec(input int k);
    logic [VW-1:0] vv;
    exp_t          e;
    for (int i = 0; i < VEC_LEN; i++) vv[i*V_WIDTH +: V_WIDTH] = V_WIDTH'(i * 100 - 3000);
    vv[0 +: V_WIDTH]       = V_WIDTH'(tbl[k].v0);
    vv[V_WIDTH +: V_WIDTH] = V_WIDTH'(tbl[k].v1);
    a_in   = SCORE_WIDTH'(tbl[k].a);
    b_in   = SCORE_WIDTH'(tbl[k].b);
    v_in   = vv;
    tag_in = TAG_WIDTH'(tbl[k].tag);
    e      = model(tbl[k].a, tbl[k].b, vv, tag_in);
    vld_in = 1'b1;
    rdy_in = 1'b1;
    #2;
    check_val($sformatf("v%0d_acc_rdy", k), rdy_out, 1);
    @(posedge clk); #1;
    vld_in = 1'b0;
    check_val($sformatf("v%0d_lat1_vld", k), vld_out, 0);
    @(posedge clk); #1;
    check_val($sformatf("v%0d_lat2_vld", k), vld_out, 0);
    @(posedge clk); #1;
    check_val($sformatf("v%0d_lat3_vld", k), vld_out, 1);
    check_val($sformatf("v%0d_lane0", k), $signed(v_out[0 +: V_WIDTH]), tbl[k].e0);
    check_val($sformatf("v%0d_lane1", k), $signed(v_out[V_WIDTH +: V_WIDTH]), tbl[k].e1);
    check_val($sformatf("v%0d_clamp", k), clamp_out, tbl[k].eclamp);
    check_val($sformatf("v%0d_zero", k), zero_out, tbl[k].ezero);
    check_val($sformatf("v%0d_tag", k), tag_out, tbl[k].tag);
    check_vec($sformatf("v%0d_all_lanes", k), v_out, e.v);
    @(posedge clk); #1;
  endtask

  initial begin
    int            sent, cyc;
    logic          pending, hold;
    logic [VW-1:0] held_v;
    logic [TAG_WIDTH-1:0] held_tag;
    logic          held_clamp, held_zero;
    exp_t          e;

    tbl[0] = '{a: 0,    b: 0,   v0: -3000,  v1: -2900,   tag: 5,  e0: -3000,  e1: -2900,   eclamp: 0, ezero: 0};
`ifdef EXPMUL_ROUND_EN
    tbl[1] = '{a: -16,  b: 0,   v0: 805,    v1: -805,    tag: 6,  e0: 101,    e1: -101,    eclamp: 0, ezero: 0};
`else
    tbl[1] = '{a: -16,  b: 0,   v0: 805,    v1: -805,    tag: 6,  e0: 100,    e1: -101,    eclamp: 0, ezero: 0};
`endif
    tbl[2] = '{a: -128, b: 127, v0: -1,     v1: -131072, tag: 7,  e0: 0,      e1: 0,       eclamp: 0, ezero: 1};
    tbl[3] = '{a: 24,   b: 8,   v0: 1234,   v1: -77,     tag: 8,  e0: 1234,   e1: -77,     eclamp: 1, ezero: 0};
`ifdef EXPMUL_ROUND_EN
    tbl[4] = '{a: -8,   b: 0,   v0: -1,     v1: 7,       tag: 9,  e0: 0,      e1: 2,       eclamp: 0, ezero: 0};
`else
    tbl[4] = '{a: -8,   b: 0,   v0: -1,     v1: 7,       tag: 9,  e0: -1,     e1: 1,       eclamp: 0, ezero: 0};
`endif
    tbl[5] = '{a: 127,  b: -128, v0: 131071, v1: -131072, tag: 10, e0: 131071, e1: -131072, eclamp: 1, ezero: 0};
`ifdef EXPMUL_ROUND_EN
    tbl[6] = '{a: -96,  b: 0,   v0: -5,     v1: -131072, tag: 11, e0: 0,      e1: -1,      eclamp: 0, ezero: 0};
`else
    tbl[6] = '{a: -96,  b: 0,   v0: -5,     v1: -131072, tag: 11, e0: -1,     e1: -1,      eclamp: 0, ezero: 0};
`endif

    rst = 1'b1; vld_in = 1'b0; rdy_in = 1'b0;
    a_in = '0; b_in = '0; v_in = '0; tag_in = '0;
    @(posedge clk); @(posedge clk); #1;
    check_val("rst_vld_out", vld_out, 0);
    check_vec("rst_v_out", v_out, '0);
    check_val("rst_tag_out", tag_out, 0);
    check_val("rst_clamp_out", clamp_out, 0);
    check_val("rst_zero_out", zero_out, 0);
    rst = 1'b0;
    #1;
    check_val("post_rst_rdy_out", rdy_out, 1);
    @(posedge clk); #1;

    for (int k = 0; k < 7; k++) run_vec(k);

    // Random traffic with periodic 3-cycle downstream stalls.
    sent = 0; cyc = 0; pending = 1'b0; hold = 1'b0;
    held_v = '0; held_tag = '0; held_clamp = 1'b0; held_zero = 1'b0;
    while ((sent < N_RAND || q.size() > 0) && cyc < 2000) begin
      rdy_in = ((cyc % 9) >= 3 && (cyc % 9) <= 5) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (!pending) begin
        if (sent < N_RAND && $urandom_range(0, 3) != 0) begin
          b_in = SCORE_WIDTH'($urandom);
          a_in = ($urandom_range(0, 1) != 0) ? SCORE_WIDTH'($urandom)
                                             : b_in - SCORE_WIDTH'($urandom_range(0, 40));
          for (int i = 0; i < VEC_LEN; i++) v_in[i*V_WIDTH +: V_WIDTH] = V_WIDTH'($urandom);
          tag_in = TAG_WIDTH'(sent);
          vld_in = 1'b1;
        end else begin
          vld_in = 1'b0;
        end
      end
      #2;
      check_val("rand_rdy_out", rdy_out, !(q.size() == 3 && !rdy_in));
      if (vld_out && rdy_in) begin
        if (q.size() == 0) begin
          check_val("rand_spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          check_vec("rand_v_out", v_out, e.v);
          check_val("rand_tag", tag_out, e.tag);
          check_val("rand_clamp", clamp_out, e.clamp);
          check_val("rand_zero", zero_out, e.zero);
        end
      end
      if (vld_in && rdy_out) begin
        q.push_back(model(int'($signed(a_in)), int'($signed(b_in)), v_in, tag_in));
        sent++;
        pending = 1'b0;
      end else begin
        pending = vld_in;
      end
      hold = vld_out && !rdy_in;
      held_v = v_out; held_tag = tag_out; held_clamp = clamp_out; held_zero = zero_out;
      @(posedge clk); #1;
      if (hold) begin
        check_val("stall_vld", vld_out, 1);
        check_vec("stall_v_out", v_out, held_v);
        check_val("stall_tag", tag_out, held_tag);
        check_val("stall_flags", {clamp_out, zero_out}, {held_clamp, held_zero});
      end
      cyc++;
    end
    vld_in = 1'b0;
    check_val("rand_all_sent", sent, N_RAND);
    check_val("rand_all_delivered", q.size(), 0);

    // Fill all three stages under a stall, then reset.
    rdy_in = 1'b0;
    for (int t = 0; t < 3; t++) begin
      a_in = SCORE_WIDTH'(-t); b_in = '0;
      for (int i = 0; i < VEC_LEN; i++) v_in[i*V_WIDTH +: V_WIDTH] = V_WIDTH'(i + 1 + t * 7);
      tag_in = TAG_WIDTH'(12 + t);
      vld_in = 1'b1;
      @(posedge clk); #1;
    end
    vld_in = 1'b0;
    #1;
    check_val("full_rdy_out", rdy_out, 0);
    check_val("full_vld_out", vld_out, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("midrst_vld_out", vld_out, 0);
    check_vec("midrst_v_out", v_out, '0);
    check_val("midrst_tag_out", tag_out, 0);
    check_val("midrst_flags", {clamp_out, zero_out}, 0);
    rst = 1'b0;
    run_vec(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/expmul_pipe.md
Name: expmul_pipe

Overview:
- Parametrised three-stage pipelined exp-multiply unit: v_out[i] = 2^-round(log2e*(b-a)) * v_in[i] ≈ exp(a-b)*v_in[i], for every lane i.
- Used by the attention datapath to rescale value/accumulator vectors when the running max changes.
- Generalises the single-stage unit: parametric score/value widths, lane count, sideband tag, positive-difference clamp, shift-overflow zeroing, and full ready/valid backpressure at every stage.

Parameters:
- VEC_LEN, 64, number of value lanes.
- V_WIDTH, 18, signed value width, two's complement.
- SCORE_WIDTH, 8, signed score width for a_in/b_in.
- SCORE_FRAC, 3, fractional bits of the scores; must satisfy 1 ≤ SCORE_FRAC < SCORE_WIDTH.
- TAG_WIDTH, 4, opaque sideband width (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- vld_in  in  1  input transaction valid.
- rdy_out  out  1  input accepted when vld_in && rdy_out.
- a_in  in  SCORE_WIDTH  signed score s.
- b_in  in  SCORE_WIDTH  signed running max m.
- v_in  in  VEC_LEN*V_WIDTH  signed value lanes; lane i at bits [i*V_WIDTH +: V_WIDTH].
- tag_in  in  TAG_WIDTH  sideband, passed through unchanged.
- vld_out  out  1  output valid.
- rdy_in  in  1  downstream ready.
- v_out  out  VEC_LEN*V_WIDTH  scaled lanes.
- tag_out  out  TAG_WIDTH  delayed tag_in.
- clamp_out  out  1  a_in > b_in; the difference was clamped to 0.
- zero_out  out  1  shift ≥ V_WIDTH; all lanes forced to 0.

Behaviour:
- Reset:
  - All stage valids are 0, so vld_out=0.
  - v_out, tag_out, clamp_out and zero_out are 0.
  - rdy_out=1 in the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight transactions; no output is produced for them.
- Handshake:
  - Each stage k keeps a valid bit. rdy_k = !vld_k || rdy_{k+1}, with rdy_4 = rdy_in and rdy_out = rdy_1.
  - The ready path is combinational end to end.
  - While vld_out && !rdy_in, every output holds stable.
  - Throughput is 1 transaction per cycle.
  - No transaction is dropped or duplicated under any vld_in/rdy_in pattern.
- Latency: a transaction accepted at edge k appears on the outputs after edge k+2 (3 register stages).
- S1: registers a_in, b_in, v_in and tag_in.
- S2 (computes the shift from the S1 registers):
  - d = a - b, signed, SCORE_WIDTH+1 bits.
  - If d > 0: clamp=1 and y=0. Otherwise y = -d (unsigned, SCORE_WIDTH+1 bits).
  - L = y + (y>>1) - (y>>4), SCORE_WIDTH+2 bits, no overflow.
  - l = (L + 2^(SCORE_FRAC-1)) >> SCORE_FRAC, i.e. round-half-up to an integer.
  - zero = (l ≥ V_WIDTH). l is registered saturated to V_WIDTH-1 using clog2(V_WIDTH) bits.
  - S2 registers l, zero, clamp, v and tag.
- S3 (per lane):
  - If zero: result is 0.
  - Otherwise: result = v[i] >>> l (arithmetic shift, i.e. floor).
  - Realised as a log-depth barrel shifter, one mux per bit of l.
  - S3 registers the result lanes, tag, clamp and zero.
- Boundaries:
  - a == b gives l=0 and v_out = v_in exactly.
  - Maximum-magnitude negative difference gives zero_out=1.
  - A negative lane with large l gives 0, never -1.

Optional Feature:
- Macro: EXPMUL_ROUND_EN.
- Defined: S3 computes (v[i] + 2^(l-1)) >>> l for l>0, using a V_WIDTH+1-bit intermediate. Results saturate to the signed V_WIDTH range and cannot overflow. l=0 passes v[i] unchanged.
- Undefined: truncating arithmetic shift only.
- zero_out forcing applies in both configurations.

Decomposition:
- Shared package expmul_pkg holds:
  - Q-format typedefs for scores and value lanes.
  - The log2e approximation function (y + y>>1 - y>>4 with rounding).
  - The localparam SHIFT_W = $clog2(V_WIDTH).
- Sub-module expmul_shift_lane: one lane's shift, round and zero logic, combinational. Instantiated VEC_LEN times inside S3.

Test Plan:
- a=0, b=0, v[i]=i*100-3000, rdy_in=1 → after 3 cycles v_out = v_in, clamp_out=0, zero_out=0, tag echoed.
- a=-16 (−2.0), b=0, v[0]=805, v[1]=-805 → l=3. Truncate: v_out = 100, -101. With EXPMUL_ROUND_EN: 101, -101.
- a=-128, b=127 → l ≥ V_WIDTH, zero_out=1, all lanes 0 including negative inputs.
- a=24, b=8 (a>b) → clamp_out=1, l=0, v_out = v_in.
- 20 back-to-back transactions with distinct tags, rdy_in toggled in a random pattern with 3-cycle stalls → outputs in order, none lost or duplicated, v_out held stable while stalled, rdy_out low only when all three stages are full.
- Assert rst mid-stream with 3 transactions in flight → vld_out=0 on the next cycle, outputs 0, and the first post-reset transaction completes with 3-cycle latency.
